// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states and
// the divide-by-zero quotient pattern.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Wide enough for any operand width up to 64; the top slices what it needs.
    localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: right-shifting shift-add for multiply, or
// left-shifting restoring subtract for divide, on unsigned magnitudes.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic             div_mode,
    input  logic             in_bit,
    output logic [WIDTH-1:0] next_acc,
    output logic             out_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           fits;

    // Multiply: in_bit is the multiplier LSB, the sum's LSB drops into the low word.
    // Divide: in_bit is the next dividend bit, out_bit is the quotient bit.
    always_comb begin
        sum      = {1'b0, acc} + (in_bit ? {1'b0, operand} : '0);
        shifted  = {acc, in_bit};
        fits     = shifted >= {1'b0, operand};
        next_acc = sum[WIDTH:1];
        out_bit  = sum[0];
        if (div_mode) begin
            next_acc = fits ? WIDTH'(shifted - {1'b0, operand}) : shifted[WIDTH-1:0];
            out_bit  = fits;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers;
// MTHI/MTLO write in a single edge, multi-cycle ops stall the core via busy.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      count;
    logic               div_mode;
    logic               b_zero;
    logic               neg_main;
    logic               neg_rem;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   a_orig;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   step_acc;
    logic               step_bit;
    logic [WIDTH-1:0]   next_work;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (operand),
        .div_mode (div_mode),
        .in_bit   (div_mode ? work[WIDTH-1] : work[0]),
        .next_acc (step_acc),
        .out_bit  (step_bit)
    );

    // work holds the multiplier (shifting out right) or dividend/quotient (shifting left).
    assign next_work   = div_mode ? {work[WIDTH-2:0], step_bit} : {step_bit, work[WIDTH-1:1]};
    assign product     = {acc, work};
    assign product_fix = neg_main ? -product : product;
    assign quot        = neg_main ? -work : work;
    assign rem         = neg_rem ? -acc : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            div_mode <= 1'b0;
            b_zero   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            operand  <= '0;
            work     <= '0;
            acc      <= '0;
            a_orig   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                div_mode <= op[1];
                                b_zero   <= (b == '0);
                                neg_main <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem  <= signed_op && a[WIDTH-1];
                                operand  <= op[1] ? b_mag : a_mag;
                                work     <= op[1] ? a_mag : b_mag;
                                acc      <= '0;
                                a_orig   <= a;
                                count    <= CW'(WIDTH - 1);
                                busy     <= 1'b1;
                                state    <= RUN;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc  <= step_acc;
                    work <= next_work;
                    if (count == '0) begin
                        state <= FINISH;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                FINISH: begin
                    if (div_mode && b_zero) begin
                        lo <= DIV0_LO[WIDTH-1:0];
                        hi <= a_orig;
                    end else if (div_mode) begin
                        lo <= quot;
                        hi <= rem;
                    end else begin
                        {hi, lo} <= product_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
